// File: rtl/blob_lunge_ctrl.sv
// blob_lunge_ctrl: per-frame lunge sequencer (advance, hold, retreat) for one blob sprite.
// Drives the renderer's x / y / stretch inputs. Motion only moves on frame_tick_in, so the
// sprite geometry never changes mid-frame.
// Optional feature: define SHAKE_EN to jitter y_out by +/-SHAKE_AMP on each HOLD tick.
module blob_lunge_ctrl #(
  parameter int unsigned HOME_X       = 100,
  parameter int unsigned HOME_Y       = 200,
  parameter int unsigned LUNGE_DIST   = 40,
  parameter int unsigned STEP         = 16,
  parameter int unsigned STRETCH_STEP = 4,
  parameter int unsigned MAX_STRETCH  = 8,
  parameter int unsigned HOLD_FRAMES  = 3,
  parameter int unsigned SHAKE_AMP    = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        frame_tick_in,
  input  logic        start_in,
  input  logic        dir_in,
  input  logic        abort_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic [10:0] stretch_out,
  output logic        busy_out,
  output logic        done_out
);

`ifdef SHAKE_EN
  localparam bit ShakeEn = 1'b1;
`else
  localparam bit ShakeEn = 1'b0;
`endif

  // HOLD_FRAMES = 0 never enters HOLD, but the counter still needs a legal width.
  localparam int unsigned HoldW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [11:0] Step12   = 12'(STEP);
  localparam logic [11:0] Dist12   = 12'(LUNGE_DIST);
  localparam logic [11:0] SStep12  = 12'(STRETCH_STEP);
  localparam logic [11:0] MaxS12   = 12'(MAX_STRETCH);
  localparam logic [10:0] Step11   = 11'(STEP);
  localparam logic [10:0] Dist11   = 11'(LUNGE_DIST);
  localparam logic [10:0] SStep11  = 11'(STRETCH_STEP);
  localparam logic [10:0] MaxS11   = 11'(MAX_STRETCH);
  localparam logic [10:0] HomeX    = 11'(HOME_X);
  localparam logic [9:0]  HomeY    = 10'(HOME_Y);
  localparam logic [9:0]  YHi      = 10'(HOME_Y + SHAKE_AMP);
  localparam logic [9:0]  YLo      = 10'(HOME_Y - SHAKE_AMP);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {StIdle, StAdvance, StHold, StRetreat} state_e;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [10:0]      off_q, off_d;
  logic [10:0]      str_q, str_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             shake_ph_q, shake_ph_d;
  logic [10:0]      x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [11:0]      off_sum, str_sum;
  logic [10:0]      off_up, off_dn, str_up, str_dn;

  // Saturating step arithmetic for advance / retreat.
  always_comb begin
    off_sum = {1'b0, off_q} + Step12;
    str_sum = {1'b0, str_q} + SStep12;
    off_up  = (off_sum >= Dist12) ? Dist11 : off_sum[10:0];
    str_up  = (str_sum >= MaxS12) ? MaxS11 : str_sum[10:0];
    off_dn  = (off_q > Step11)  ? (off_q - Step11)  : 11'd0;
    str_dn  = (str_q > SStep11) ? (str_q - SStep11) : 11'd0;
  end

  // Sequencer next-state and registered-output next values.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    off_d      = off_q;
    str_d      = str_q;
    hold_cnt_d = hold_cnt_q;
    shake_ph_d = shake_ph_q;
    done_d     = 1'b0;
    // y leaves the shake value one cycle after HOLD is exited.
    y_d        = (state_q == StHold) ? y_q : HomeY;

    unique case (state_q)
      StIdle: begin
        // A tick coincident with start is not consumed; abort is ignored here.
        if (start_in) begin
          state_d = StAdvance;
          dir_d   = dir_in;
        end
      end
      StAdvance: begin
        if (frame_tick_in) begin
          off_d = off_up;
          str_d = str_up;
          if (off_up == Dist11) begin
            state_d    = (HOLD_FRAMES == 0) ? StRetreat : StHold;
            hold_cnt_d = '0;
            shake_ph_d = 1'b0;
          end
        end
        if (abort_in) state_d = StRetreat;
      end
      StHold: begin
        if (frame_tick_in) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          shake_ph_d = ~shake_ph_q;
          if (ShakeEn) y_d = shake_ph_q ? YLo : YHi;
          if (hold_cnt_q == HoldLast) state_d = StRetreat;
        end
        if (abort_in) state_d = StRetreat;
      end
      StRetreat: begin
        if (frame_tick_in) begin
          off_d = off_dn;
          str_d = str_dn;
          if (off_dn == 11'd0) begin
            str_d   = 11'd0;
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    x_d    = dir_d ? (HomeX + off_d) : (HomeX - off_d);
    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; reset returns the sprite home with no done pulse.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StIdle;
      dir_q      <= 1'b1;
      off_q      <= 11'd0;
      str_q      <= 11'd0;
      hold_cnt_q <= '0;
      shake_ph_q <= 1'b0;
      x_q        <= HomeX;
      y_q        <= HomeY;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      off_q      <= off_d;
      str_q      <= str_d;
      hold_cnt_q <= hold_cnt_d;
      shake_ph_q <= shake_ph_d;
      x_q        <= x_d;
      y_q        <= y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign x_out       = x_q;
  assign y_out       = y_q;
  assign stretch_out = str_q;
  assign busy_out    = busy_q;
  assign done_out    = done_q;

endmodule

// File: tb/tb_blob_lunge_ctrl.sv
// Bench for blob_lunge_ctrl: two instances (default, and LUNGE_DIST=32 / HOLD_FRAMES=0)
// checked every cycle against a behavioural model, plus literal trajectory pins.
module tb_blob_lunge_ctrl;
  localparam int HX = 100, HY = 200, STEP = 16, SS = 4, MAXS = 8, AMP = 2;
`ifdef SHAKE_EN
  localparam bit SHAKE = 1'b1;
`else
  localparam bit SHAKE = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, start = 1'b0, dir = 1'b0, abort = 1'b0;
  logic [10:0] x_o[2];
  logic [9:0]  y_o[2];
  logic [10:0] s_o[2];
  logic        busy_o[2];
  logic        done_o[2];

  int n_vec = 0, n_err = 0;
  int p_dist[2] = '{40, 32};
  int p_hold[2] = '{3, 0};

  // Model: phase 0 idle, 1 advance, 2 hold, 3 retreat.
  int m_phase[2], m_off[2], m_str[2], m_dir[2], m_hcnt[2], m_y[2], m_done[2];

  always #5 clk = ~clk;

  blob_lunge_ctrl u_dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .frame_tick_in(tick), .start_in(start), .dir_in(dir),
    .abort_in(abort), .x_out(x_o[0]), .y_out(y_o[0]), .stretch_out(s_o[0]),
    .busy_out(busy_o[0]), .done_out(done_o[0])
  );

  blob_lunge_ctrl #(.LUNGE_DIST(32), .HOLD_FRAMES(0)) u_dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .frame_tick_in(tick), .start_in(start), .dir_in(dir),
    .abort_in(abort), .x_out(x_o[1]), .y_out(y_o[1]), .stretch_out(s_o[1]),
    .busy_out(busy_o[1]), .done_out(done_o[1])
  );

  task automatic check(input string nm, input int k, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, k, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_off[k] = 0; m_str[k] = 0; m_dir[k] = 1;
      m_hcnt[k] = 0; m_y[k] = HY; m_done[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int old;
      old = m_phase[k];
      m_done[k] = 0;
      if (old != 2) m_y[k] = HY;
      case (old)
        0: if (start) begin m_dir[k] = int'(dir); m_phase[k] = 1; end
        1: begin
          if (tick) begin
            m_off[k] = (m_off[k] + STEP > p_dist[k]) ? p_dist[k] : m_off[k] + STEP;
            m_str[k] = (m_str[k] + SS > MAXS) ? MAXS : m_str[k] + SS;
            if (m_off[k] == p_dist[k]) begin
              m_phase[k] = (p_hold[k] > 0) ? 2 : 3;
              m_hcnt[k] = 0;
            end
          end
          if (abort) m_phase[k] = 3;
        end
        2: begin
          if (tick) begin
            m_hcnt[k]++;
            if (SHAKE) m_y[k] = (m_hcnt[k] % 2 == 1) ? HY + AMP : HY - AMP;
            if (m_hcnt[k] == p_hold[k]) m_phase[k] = 3;
          end
          if (abort) m_phase[k] = 3;
        end
        default: begin
          if (tick) begin
            m_off[k] = (m_off[k] > STEP) ? m_off[k] - STEP : 0;
            m_str[k] = (m_str[k] > SS) ? m_str[k] - SS : 0;
            if (m_off[k] == 0) begin m_str[k] = 0; m_phase[k] = 0; m_done[k] = 1; end
          end
        end
      endcase
    end
  endtask

  // Model advances on the same edges the DUT sees.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Compare every output of both instances on every falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check("x", k, int'(x_o[k]), m_dir[k] != 0 ? HX + m_off[k] : HX - m_off[k]);
      check("y", k, int'(y_o[k]), m_y[k]);
      check("stretch", k, int'(s_o[k]), m_str[k]);
      check("busy", k, int'(busy_o[k]), (m_phase[k] != 0) ? 1 : 0);
      check("done", k, int'(done_o[k]), m_done[k]);
    end
  end

  // Inputs change just after a falling edge and hold across the next rising edge.
  task automatic drive(input bit t, input bit s, input bit d, input bit a);
    tick = t; start = s; dir = d; abort = a;
    @(negedge clk);
  endtask

  int ex0[9] = '{116, 132, 140, 140, 140, 140, 124, 108, 100};
  int es0[9] = '{4, 8, 8, 8, 8, 8, 4, 0, 0};
  int ey0[9];
  int ex1[4] = '{116, 132, 116, 100};
  int es1[4] = '{4, 8, 4, 0};

  initial begin
    model_reset();
    for (int i = 0; i < 9; i++) ey0[i] = HY;
    if (SHAKE) begin ey0[3] = HY + AMP; ey0[4] = HY - AMP; ey0[5] = HY + AMP; end

    repeat (3) @(negedge clk);
    check("lit_rst_x", 0, int'(x_o[0]), 100);
    check("lit_rst_busy", 0, int'(busy_o[0]), 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0);

    // Full lunge, dir=1; start with a coincident tick that must not move the sprite.
    drive(1, 1, 1, 0);
    check("lit_start_x", 0, int'(x_o[0]), 100);
    check("lit_start_busy", 0, int'(busy_o[0]), 1);
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, 0);
      check("lit_x", 0, int'(x_o[0]), ex0[i]);
      check("lit_stretch", 0, int'(s_o[0]), es0[i]);
      check("lit_y", 0, int'(y_o[0]), ey0[i]);
      if (i == 8) check("lit_done", 0, int'(done_o[0]), 1);
      if (i < 4) begin
        check("lit_x", 1, int'(x_o[1]), ex1[i]);
        check("lit_stretch", 1, int'(s_o[1]), es1[i]);
      end
      if (i == 3) check("lit_done", 1, int'(done_o[1]), 1);
      // Start while busy must be ignored.
      drive(0, (i == 1), 0, 0);
      drive(0, 0, 0, 0);
    end
    check("lit_idle_busy", 0, int'(busy_o[0]), 0);

    // dir=0, abort after the first tick.
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    check("lit_dir0_x", 0, int'(x_o[0]), 84);
    drive(0, 0, 0, 1);
    drive(1, 0, 0, 0);
    check("lit_abort_x", 0, int'(x_o[0]), 100);
    check("lit_abort_done", 0, int'(done_o[0]), 1);
    drive(0, 0, 0, 0);

    // Reset asserted mid-HOLD.
    drive(0, 1, 1, 0);
    repeat (4) drive(1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("lit_mr_x", 0, int'(x_o[0]), 100);
    check("lit_mr_y", 0, int'(y_o[0]), 200);
    check("lit_mr_stretch", 0, int'(s_o[0]), 0);
    check("lit_mr_busy", 0, int'(busy_o[0]), 0);
    check("lit_mr_done", 0, int'(done_o[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) drive(0, 0, 0, 0);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
